io_walk_checker: RTL and testbench

- Receive-side counterpart of the walking-one IO pin test pattern generator.
- Samples NUM_PINS board IO inputs looped back from a board driving a one-hot walking pattern (index 0..NUM_PINS-1, wrapping). Verifies every step of the pattern and reports stuck-low and shorted/stuck-high pins per bit.
- Sits in the board bring-up gateware; its pass/done outputs drive status LEDs.

---
 rtl/io_test_pkg.sv | 23 ++
 rtl/io_sync.sv | 21 ++
 rtl/io_walk_checker.sv | 172 +++++++++++++++++
 tb/tb_io_walk_checker.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_test_pkg.sv
// io_test_pkg: types and helpers shared by the walking-one
// pattern generator and its loopback checker.
package io_test_pkg;

  localparam int DEFAULT_NUM_PINS = 20;
  localparam int ONEHOT_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    WAIT_CHANGE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  function automatic logic [ONEHOT_W-1:0] onehot(
    input int unsigned idx
  );
    return {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/io_sync.sv
// io_sync: two-flop synchronizer for asynchronous board inputs.
// Data flops carry no reset; they flush within two cycles.
module io_sync #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    r_meta <= i_d;
    r_sync <= r_meta;
  end

  assign o_q = r_sync;

endmodule

// File: rtl/io_walk_checker.sv
// io_walk_checker: checks a looped-back walking-one pattern and
// reports stuck-low and shorted pins per bit.
module io_walk_checker
  import io_test_pkg::*;
#(
  parameter int NUM_PINS       = DEFAULT_NUM_PINS,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int NUM_SWEEPS     = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [NUM_PINS-1:0]         i_io_in,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pass,
  output logic                        o_timeout,
  output logic [NUM_PINS-1:0]         o_fail_stuck_low,
  output logic [NUM_PINS-1:0]         o_fail_short,
  output logic [$clog2(NUM_PINS)-1:0] o_index
);

  localparam int IW = $clog2(NUM_PINS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int NW = $clog2(NUM_SWEEPS + 1);

  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_SWEEPS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_PINS - 1);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_timeout;
  logic [NUM_PINS-1:0] r_fsl;
  logic [NUM_PINS-1:0] r_fsh;
  logic [NUM_PINS-1:0] r_last;
  logic [NUM_PINS-1:0] r_prev;
  logic [IW-1:0]       r_index;
  logic [NW-1:0]       r_sweep;
  logic [TW-1:0]       r_timer;
  logic [SW-1:0]       r_settle;

  logic [NUM_PINS-1:0] w_sync;
  logic [NUM_PINS-1:0] w_oh0;
  logic [NUM_PINS-1:0] w_oh_nxt;
  logic [IW-1:0]       w_nxt;
  logic [TW-1:0]       w_timer_inc;
  logic [SW-1:0]       w_settle_inc;
  logic                w_chg;
  logic                w_stable;
  logic                w_tmo;

  io_sync #(
    .W(NUM_PINS)
  ) u_sync (
    .i_clk(i_clk),
    .i_d  (i_io_in),
    .o_q  (w_sync)
  );

  assign w_nxt    = (r_index == I_LAST) ? '0 : r_index + 1'b1;
  assign w_oh0    = NUM_PINS'(onehot(0));
  assign w_oh_nxt = NUM_PINS'(onehot(32'(w_nxt)));

  // Both counters saturate so a stuck board can never wrap them.
  assign w_timer_inc  = (r_timer < T_MAX) ? r_timer + 1'b1 : r_timer;
  assign w_settle_inc = (r_settle < S_MAX) ? r_settle + 1'b1 : r_settle;

  assign w_chg    = (w_sync != r_prev);
  assign w_stable = !w_chg && (r_settle >= S_LAST);
  assign w_tmo    = (r_timer >= T_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_fsl     <= '0;
      r_fsh     <= '0;
      r_last    <= '0;
      r_prev    <= '0;
      r_index   <= '0;
      r_sweep   <= '0;
      r_timer   <= '0;
      r_settle  <= '0;
    end else begin
      r_prev <= w_sync;
      unique case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_fsl     <= '0;
            r_fsh     <= '0;
            r_timeout <= 1'b0;
            r_index   <= '0;
            r_sweep   <= '0;
            r_timer   <= '0;
            r_settle  <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_state   <= ALIGN;
          end
        end
        ALIGN: begin
          r_timer  <= w_timer_inc;
          r_settle <= w_chg ? '0 : w_settle_inc;
          if (w_stable && (w_sync == w_oh0)) begin
            r_index <= '0;
            r_last  <= w_sync;
            r_state <= WAIT_CHANGE;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_fsl[0]  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        WAIT_CHANGE: begin
          r_timer <= w_timer_inc;
          if (w_sync != r_last) begin
            r_settle <= '0;
            r_state  <= SETTLE;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_state   <= CHECK;
          end
        end
        SETTLE: begin
          r_timer  <= w_timer_inc;
          r_settle <= w_chg ? '0 : w_settle_inc;
          // Settling back onto the old value was only a glitch.
          if (w_stable) begin
            r_state <= (w_sync == r_last) ? WAIT_CHANGE : CHECK;
          end
        end
        CHECK: begin
          r_fsl   <= r_fsl | (w_oh_nxt & ~w_sync);
          r_fsh   <= r_fsh | (w_sync & ~w_oh_nxt);
          r_index <= w_nxt;
          r_last  <= w_sync;
          r_timer <= '0;
          r_state <= WAIT_CHANGE;
          if (w_nxt == I_LAST) begin
            r_sweep <= r_sweep + 1'b1;
            if (r_sweep >= N_LAST) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_timeout        = r_timeout;
  assign o_fail_stuck_low = r_fsl;
  assign o_fail_short     = r_fsh;
  assign o_index          = r_index;
  assign o_pass           = r_done & ~r_timeout & ~|r_fsl & ~|r_fsh;

endmodule

// File: tb/tb_io_walk_checker.sv
// tb_io_walk_checker: directed and randomized walking-one runs
// checked against a pattern-level reference model.
module tb_io_walk_checker;

  localparam int NP = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic [NP-1:0] io    = '0;
  logic          busy, done, pass, tmo;
  logic [NP-1:0] fsl, fsh;
  logic [1:0]    idx;

  int n_pass = 0;
  int n_tot  = 0;

  logic [NP-1:0] pat [NP];
  logic [NP-1:0] gm  [NP];
  bit            mid_start = 1'b0;
  bit            walk_ok;
  logic          busy_mid;

  always #5 clk = ~clk;

  io_walk_checker #(
    .NUM_PINS      (NP),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(64),
    .NUM_SWEEPS    (1)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_io_in         (io),
    .o_busy          (busy),
    .o_done          (done),
    .o_pass          (pass),
    .o_timeout       (tmo),
    .o_fail_stuck_low(fsl),
    .o_fail_short    (fsh),
    .o_index         (idx)
  );

  function automatic logic [NP-1:0] oh(input int k);
    return NP'(1) << k;
  endfunction

  // Board fault: a shorted pair both rise if either is driven.
  function automatic logic [NP-1:0] fault(
    input logic [NP-1:0] v,
    input logic [NP-1:0] sl,
    input logic [NP-1:0] sh
  );
    logic [NP-1:0] r;
    r = v;
    if ((v & sh) != '0) r = r | sh;
    return r & ~sl;
  endfunction

  // Each step k>0 is expected to show exactly pin k high.
  function automatic void model(
    output logic [NP-1:0] esl,
    output logic [NP-1:0] esh
  );
    esl = '0;
    esh = '0;
    for (int k = 1; k < NP; k++) begin
      esl |= oh(k) & ~pat[k];
      esh |= pat[k] & ~oh(k);
    end
  endfunction

  task automatic clean_pat();
    for (int k = 0; k < NP; k++) begin
      pat[k] = oh(k);
      gm[k]  = '0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    walk_ok = 1'b0;
    for (int c = 0; c < lim && !walk_ok; c++) begin
      if (done) walk_ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic run_walk();
    io = pat[0];
    repeat (8) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    busy_mid = busy;
    for (int k = 1; k < NP; k++) begin
      io = pat[k];
      for (int c = 0; c < 20; c++) begin
        if (c == 10 && gm[k] != '0 && k < NP - 1)
          io = pat[k] ^ gm[k];
        if (c == 12) io = pat[k];
        if (mid_start && k == 2) start = (c == 15);
        @(negedge clk);
      end
    end
    wait_done(100);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    io    = 4'b0101;
    repeat (4) @(negedge clk);
    n_tot++;
    if ({busy, done, pass, tmo, fsl, fsh, idx} !== '0)
      $display("FAIL reset_outputs got=%b want=0",
               {busy, done, pass, tmo, fsl, fsh, idx});
    else n_pass++;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tot++;
    if ({busy, done} !== 2'b00)
      $display("FAIL reset_idle busy/done got=%b want=00",
               {busy, done});
    else n_pass++;
  endtask

  task automatic test_clean();
    clean_pat();
    run_walk();
    n_tot++;
    if (!walk_ok || busy_mid !== 1'b1)
      $display("FAIL clean_run done=%0b busy_mid=%b want 1/1",
               walk_ok, busy_mid);
    else n_pass++;
    n_tot++;
    if ({pass, tmo, busy, idx} !== 5'b10011)
      $display("FAIL clean_status pass,tmo,busy,idx got=%b want=10011",
               {pass, tmo, busy, idx});
    else n_pass++;
    n_tot++;
    if ({fsl, fsh} !== 8'h00)
      $display("FAIL clean_vectors got=%b_%b want=0000_0000",
               fsl, fsh);
    else n_pass++;
  endtask

  task automatic test_stuck_low();
    clean_pat();
    pat[2] = '0;
    run_walk();
    n_tot++;
    if (!walk_ok || {done, pass, tmo} !== 3'b100)
      $display("FAIL stuck_status ok=%0b done,pass,tmo=%b want 1/100",
               walk_ok, {done, pass, tmo});
    else n_pass++;
    n_tot++;
    if (fsl !== 4'b0100 || fsh !== 4'b0000)
      $display("FAIL stuck_vectors got=%b_%b want=0100_0000",
               fsl, fsh);
    else n_pass++;
  endtask

  task automatic test_short();
    clean_pat();
    for (int k = 0; k < NP; k++)
      pat[k] = fault(oh(k), '0, 4'b1010);
    run_walk();
    n_tot++;
    if (!walk_ok || {done, pass, tmo} !== 3'b100)
      $display("FAIL short_status ok=%0b done,pass,tmo=%b want 1/100",
               walk_ok, {done, pass, tmo});
    else n_pass++;
    n_tot++;
    if (fsl !== 4'b0000 || fsh !== 4'b1010)
      $display("FAIL short_vectors got=%b_%b want=0000_1010",
               fsl, fsh);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    io = '0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_tot++;
    if (n != 64)
      $display("FAIL timeout_latency got=%0d want=64", n);
    else n_pass++;
    n_tot++;
    if ({done, pass, tmo, busy} !== 4'b1010)
      $display("FAIL timeout_status done,pass,tmo,busy=%b want=1010",
               {done, pass, tmo, busy});
    else n_pass++;
    n_tot++;
    if (fsl !== 4'b0001 || fsh !== 4'b0000)
      $display("FAIL timeout_vectors got=%b_%b want=0001_0000",
               fsl, fsh);
    else n_pass++;
  endtask

  task automatic test_stall();
    io = oh(0);
    repeat (8) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    io = oh(1);
    wait_done(400);
    n_tot++;
    if (!walk_ok || {pass, tmo, idx} !== 4'b0111)
      $display("FAIL stall_status ok=%0b pass,tmo,idx=%b want 1/0111",
               walk_ok, {pass, tmo, idx});
    else n_pass++;
    n_tot++;
    if (fsl !== 4'b1100 || fsh !== 4'b0010)
      $display("FAIL stall_vectors got=%b_%b want=1100_0010",
               fsl, fsh);
    else n_pass++;
  endtask

  task automatic test_glitch();
    clean_pat();
    gm[1] = 4'b0001;
    run_walk();
    n_tot++;
    if (!walk_ok || {pass, tmo, idx} !== 4'b1011)
      $display("FAIL glitch_status ok=%0b pass,tmo,idx=%b want 1/1011",
               walk_ok, {pass, tmo, idx});
    else n_pass++;
    n_tot++;
    if ({fsl, fsh} !== 8'h00)
      $display("FAIL glitch_vectors got=%b_%b want=0000_0000",
               fsl, fsh);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    clean_pat();
    mid_start = 1'b1;
    run_walk();
    mid_start = 1'b0;
    start = 1'b0;
    n_tot++;
    if (!walk_ok || {pass, tmo, fsl, fsh} !== 10'b10_0000_0000)
      $display("FAIL midstart ok=%0b pass,tmo,fsl,fsh=%b want 1/1000000000",
               walk_ok, {pass, tmo, fsl, fsh});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    clean_pat();
    io = pat[0];
    repeat (8) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    io = pat[1];
    repeat (20) @(negedge clk);
    io = pat[2];
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (idx == 2'd2) found = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    n_tot++;
    if (!found || {busy, done, pass, tmo, fsl, fsh, idx} !== '0)
      $display("FAIL rst_mid found=%0b got=%b want=0",
               found, {busy, done, pass, tmo, fsl, fsh, idx});
    else n_pass++;
    rst = 1'b0;
    run_walk();
    n_tot++;
    if (!walk_ok || {pass, tmo, fsl, fsh} !== 10'b10_0000_0000)
      $display("FAIL rst_rerun ok=%0b pass,tmo,fsl,fsh=%b want 1/1000000000",
               walk_ok, {pass, tmo, fsl, fsh});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NP-1:0] sl, sh, esl, esh;
    logic          epass;
    bit            good;
    int            a, b;
    for (int it = 0; it < 12; it++) begin
      good = 1'b0;
      for (int t = 0; t < 50 && !good; t++) begin
        sl = NP'($urandom) & ~oh(0);
        sh = '0;
        if ($urandom_range(0, 1) == 1) begin
          a  = int'($urandom_range(0, NP - 1));
          b  = (a + int'($urandom_range(1, NP - 1))) % NP;
          sh = oh(a) | oh(b);
        end
        for (int k = 0; k < NP; k++)
          pat[k] = fault(oh(k), sl, sh);
        good = (pat[0] == oh(0));
        for (int k = 1; k < NP; k++)
          if (pat[k] == pat[k-1]) good = 1'b0;
      end
      if (!good) clean_pat();
      for (int k = 0; k < NP; k++)
        gm[k] = ($urandom_range(0, 2) == 0) ?
                NP'($urandom_range(1, (1 << NP) - 1)) : '0;
      model(esl, esh);
      epass = (esl == '0) && (esh == '0);
      run_walk();
      n_tot++;
      if (!walk_ok || {pass, tmo, idx} !== {epass, 1'b0, 2'd3})
        $display("FAIL rand%0d_status ok=%0b got=%b want=%b",
                 it, walk_ok, {pass, tmo, idx},
                 {epass, 1'b0, 2'd3});
      else n_pass++;
      n_tot++;
      if (fsl !== esl)
        $display("FAIL rand%0d_stuck got=%b want=%b", it, fsl, esl);
      else n_pass++;
      n_tot++;
      if (fsh !== esh)
        $display("FAIL rand%0d_short got=%b want=%b", it, fsh, esh);
      else n_pass++;
    end
  endtask

  initial begin
    clean_pat();
    test_reset();
    test_clean();
    test_stuck_low();
    test_short();
    test_timeout();
    test_stall();
    test_glitch();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
